branch_res_queue: RTL

BRANCH_RES_QUEUE -- requirements
Module: branch_res_queue

---
 rtl/mmm_pkg.sv | 23 ++
 rtl/branch_res_queue.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mmm_pkg.sv
// Shared front-end definitions: datapath widths, branch queue defaults, entry and FSM types.
package mmm_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned HLEN      = 8;
    // Byte distance from a branch to its fall-through instruction.
    localparam int unsigned OFFSET    = 4;
    localparam int unsigned BRQ_DEPTH = 8;

    // One in-flight predicted conditional branch.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [HLEN-1:0] index;
        logic            taken;
        logic [XLEN-1:0] target;
    } brq_entry_t;

    typedef enum logic [0:0] {
        StRun,
        StRecover
    } brq_state_e;

endpackage

// File: rtl/branch_res_queue.sv
// Branch resolution queue: holds predicted branches in program order until execute resolves
// them, trains the predictor one cycle after each resolution and raises a one-cycle redirect
// when a prediction turns out wrong. DEPTH must be a power of two and at least 2.
module branch_res_queue
    import mmm_pkg::*;
#(
    parameter int unsigned DEPTH = BRQ_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       flush_i,

    input  logic                       push_valid_i,
    output logic                       push_ready_o,
    input  logic [XLEN-1:0]            push_pc_i,
    input  logic [HLEN-1:0]            push_index_i,
    input  logic                       push_taken_i,
    input  logic [XLEN-1:0]            push_target_i,

    input  logic                       res_valid_i,
    output logic                       res_ready_o,
    input  logic                       res_taken_i,
    input  logic [XLEN-1:0]            res_target_i,

    output logic                       upd_valid_o,
    output logic [HLEN-1:0]            upd_index_o,
    output logic                       upd_taken_o,

    output logic                       mispredict_o,
    output logic [XLEN-1:0]            redirect_pc_o,

    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned PtrW = IdxW + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    brq_state_e      state_q, state_d;

    brq_entry_t      mem_q [DEPTH];
    brq_entry_t      head;
    brq_entry_t      push_entry;

    logic            full, empty;
    logic            push_hs, res_hs;
    logic            mispredict;
    logic            mem_we;

    logic            upd_valid_q, upd_valid_d;
    logic [HLEN-1:0] upd_index_q, upd_index_d;
    logic            upd_taken_q, upd_taken_d;
    logic            mispredict_q, mispredict_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

    // Status, handshakes and mispredict detection from registered state.
    always_comb begin
        empty        = (wr_ptr_q == rd_ptr_q);
        full         = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                       (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);
        push_ready_o = (state_q == StRun) && !full;
        res_ready_o  = (state_q == StRun) && !empty;
        push_hs      = push_valid_i && push_ready_o;
        res_hs       = res_valid_i && res_ready_o;
        head         = mem_q[rd_ptr_q[IdxW-1:0]];
        mispredict   = res_hs &&
                       ((res_taken_i != head.taken) ||
                        (res_taken_i && head.taken && (res_target_i != head.target)));
        // Wrong-path pushes and flushed pushes never land in storage.
        mem_we       = push_hs && !flush_i && !mispredict;
        push_entry   = '{pc: push_pc_i, index: push_index_i, taken: push_taken_i,
                         target: push_target_i};
        count_o      = wr_ptr_q - rd_ptr_q;
    end

    // Next-state for FSM, pointers and registered outputs; flush beats mispredict recovery.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        upd_valid_d   = 1'b0;
        upd_index_d   = '0;
        upd_taken_d   = 1'b0;
        mispredict_d  = 1'b0;
        redirect_pc_d = '0;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            state_d  = StRun;
        end else begin
            if (res_hs) begin
                upd_valid_d = 1'b1;
                upd_index_d = head.index;
                upd_taken_d = res_taken_i;
            end

            unique case (state_q)
                StRun: begin
                    if (mispredict) begin
                        // Drop every younger entry by collapsing the write pointer onto
                        // the post-pop read pointer.
                        rd_ptr_d      = rd_ptr_q + PtrW'(1);
                        wr_ptr_d      = rd_ptr_q + PtrW'(1);
                        state_d       = StRecover;
                        mispredict_d  = 1'b1;
                        redirect_pc_d = res_taken_i ? res_target_i : head.pc + XLEN'(OFFSET);
                    end else begin
                        if (push_hs) wr_ptr_d = wr_ptr_q + PtrW'(1);
                        if (res_hs)  rd_ptr_d = rd_ptr_q + PtrW'(1);
                    end
                end
                StRecover: begin
                    state_d = StRun;
                end
                default: begin
                    state_d = StRun;
                end
            endcase
        end
    end

    // Control state and registered outputs, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= StRun;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            upd_valid_q   <= 1'b0;
            upd_index_q   <= '0;
            upd_taken_q   <= 1'b0;
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            upd_valid_q   <= upd_valid_d;
            upd_index_q   <= upd_index_d;
            upd_taken_q   <= upd_taken_d;
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    // Entry payload storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[wr_ptr_q[IdxW-1:0]] <= push_entry;
        end
    end

    assign upd_valid_o   = upd_valid_q;
    assign upd_index_o   = upd_index_q;
    assign upd_taken_o   = upd_taken_q;
    assign mispredict_o  = mispredict_q;
    assign redirect_pc_o = redirect_pc_q;

endmodule
